// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse receiver: frame FSM states,
// frame geometry and the bit positions of the packed MOUSE word.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } frame_state_t;

   localparam int FRAME_BITS = 11;
   localparam int DATA_BITS  = FRAME_BITS - 3;

   localparam int MOUSE_W    = 25;
   localparam int B0_LSB     = 0;
   localparam int B1_LSB     = 8;
   localparam int B2_LSB     = 16;
   localparam int TOGGLE_BIT = 24;

   // True when data plus parity bit hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchronizers for PS2_CLK/PS2_DATA plus a run-length glitch filter
// on the clock that emits a one-cycle pulse on each filtered falling edge.
module ps2_filter #(
   parameter int FILTER = 8
) (
   input  logic CLK,
   input  logic RESET,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic data_sync,
   output logic clk_fall
);

   localparam int CW = $clog2(FILTER + 1);

   logic [1:0]    clk_meta;
   logic [1:0]    data_meta;
   logic          clk_filt;
   logic [CW-1:0] run_cnt;

   // The filtered level flips only after FILTER consecutive samples disagree
   // with it; any agreeing sample restarts the run.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         clk_meta  <= 2'b11;
         data_meta <= 2'b11;
         clk_filt  <= 1'b1;
         run_cnt   <= '0;
         clk_fall  <= 1'b0;
      end else begin
         clk_meta  <= {clk_meta[0], ps2_clk};
         data_meta <= {data_meta[0], ps2_data};
         clk_fall  <= 1'b0;
         if (clk_meta[1] == clk_filt) begin
            run_cnt <= '0;
         end else if (run_cnt == CW'(FILTER - 1)) begin
            clk_filt <= clk_meta[1];
            run_cnt  <= '0;
            clk_fall <= ~clk_meta[1];
         end else begin
            run_cnt <= run_cnt + 1'b1;
         end
      end
   end

   assign data_sync = data_meta[1];

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: frames bytes, checks parity/stop/sync bit and publishes
// complete 3-byte packets on MOUSE with a toggle strobe in bit 24.
// Optional watchdog enabled by defining PS2_MOUSE_TIMEOUT_EN.
module ps2_mouse_rx
   import ps2_pkg::*;
#(
   parameter int FILTER  = 8,
   parameter int TIMEOUT = 60000
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               PS2_CLK,
   input  logic               PS2_DATA,
   output logic [MOUSE_W-1:0] MOUSE,
   output logic               ERR
);

   logic         data_bit;
   logic         fall;
   frame_state_t state;
   logic [3:0]   bit_cnt;
   logic [7:0]   shift_reg;
   logic         parity_bit;
   logic [1:0]   pkt_idx;
   logic [7:0]   byte0_q;
   logic [7:0]   byte1_q;

`ifdef PS2_MOUSE_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd_cnt;
`endif

   ps2_filter #(
      .FILTER(FILTER)
   ) u_filter (
      .CLK      (CLK),
      .RESET    (RESET),
      .ps2_clk  (PS2_CLK),
      .ps2_data (PS2_DATA),
      .data_sync(data_bit),
      .clk_fall (fall)
   );

   // Frame and packet assembly advance only on filtered falling edges; MOUSE
   // is rewritten in one shot so partial packets never leak out.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         pkt_idx    <= '0;
         byte0_q    <= '0;
         byte1_q    <= '0;
         MOUSE      <= '0;
         ERR        <= 1'b0;
`ifdef PS2_MOUSE_TIMEOUT_EN
         wd_cnt     <= '0;
`endif
      end else begin
         ERR <= 1'b0;
         if (fall) begin
`ifdef PS2_MOUSE_TIMEOUT_EN
            wd_cnt <= '0;
`endif
            case (state)
               ST_IDLE: begin
                  if (!data_bit) begin
                     state   <= ST_DATA;
                     bit_cnt <= '0;
                  end
               end
               ST_DATA: begin
                  shift_reg <= {data_bit, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 1'b1;
                  if (bit_cnt == 4'(DATA_BITS - 1)) begin
                     state <= ST_PARITY;
                  end
               end
               ST_PARITY: begin
                  parity_bit <= data_bit;
                  state      <= ST_STOP;
               end
               ST_STOP: begin
                  state   <= ST_IDLE;
                  bit_cnt <= '0;
                  if (!data_bit || !odd_parity_ok(shift_reg, parity_bit)) begin
                     ERR     <= 1'b1;
                     pkt_idx <= '0;
                  end else if (pkt_idx == 2'd0 && !shift_reg[3]) begin
                     ERR <= 1'b1;
                  end else begin
                     case (pkt_idx)
                        2'd0: begin
                           byte0_q <= shift_reg;
                           pkt_idx <= 2'd1;
                        end
                        2'd1: begin
                           byte1_q <= shift_reg;
                           pkt_idx <= 2'd2;
                        end
                        default: begin
                           MOUSE   <= {~MOUSE[TOGGLE_BIT], shift_reg, byte1_q, byte0_q};
                           pkt_idx <= '0;
                        end
                     endcase
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
`ifdef PS2_MOUSE_TIMEOUT_EN
         // A stalled frame or packet is abandoned after TIMEOUT quiet cycles.
         else if (state != ST_IDLE || pkt_idx != 2'd0) begin
            if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
               state   <= ST_IDLE;
               bit_cnt <= '0;
               pkt_idx <= '0;
               ERR     <= 1'b1;
               wd_cnt  <= '0;
            end else begin
               wd_cnt <= wd_cnt + 1'b1;
            end
         end else begin
            wd_cnt <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Self-checking bench for ps2_mouse_rx: directed scenarios plus randomized
// packets checked against a byte-level packet model.
module tb_ps2_mouse_rx;

   localparam int FILTER  = 8;
   localparam int TIMEOUT = 100;
   localparam int HALF    = 20;
   localparam int GAP     = 30;

   logic        CLK;
   logic        RESET;
   logic        PS2_CLK;
   logic        PS2_DATA;
   logic [24:0] MOUSE;
   logic        ERR;

   int checks;
   int errors;

   logic [24:0] exp_mouse;
   int          exp_errs;
   int          exp_toggles;
   int          exp_idx;
   logic [7:0]  pkt [3];

   int          err_cycles;
   int          err_pulses;
   int          toggles;
   int          stab_viol;
   logic        err_prev;
   logic        rst_prev;
   logic [24:0] mouse_prev;

   ps2_mouse_rx #(
      .FILTER (FILTER),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .PS2_CLK (PS2_CLK),
      .PS2_DATA(PS2_DATA),
      .MOUSE   (MOUSE),
      .ERR     (ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Observers for ERR pulse width, toggle count and MOUSE stability.
   always @(posedge CLK) begin
      if (!RESET) begin
         if (ERR) err_cycles++;
         if (ERR && !err_prev) err_pulses++;
         if (!rst_prev && MOUSE[24] != mouse_prev[24]) toggles++;
         if (!rst_prev && MOUSE[23:0] != mouse_prev[23:0] && MOUSE[24] == mouse_prev[24])
            stab_viol++;
      end
      err_prev   <= ERR;
      rst_prev   <= RESET;
      mouse_prev <= MOUSE;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Byte-level model of the packet rules.
   task automatic model_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      if (bad_par || bad_stop) begin
         exp_errs++;
         exp_idx = 0;
      end else if (exp_idx == 0 && !b[3]) begin
         exp_errs++;
      end else begin
         pkt[exp_idx] = b;
         exp_idx++;
         if (exp_idx == 3) begin
            exp_mouse = {~exp_mouse[24], pkt[2], pkt[1], pkt[0]};
            exp_toggles++;
            exp_idx = 0;
         end
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int glitch_bit, input int nbits);
      logic [10:0] bits;
      bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         PS2_DATA = bits[i];
         wait_clk(HALF);
         if (i == glitch_bit) begin
            PS2_CLK = 1'b0;
            wait_clk(FILTER - 1);
            PS2_CLK = 1'b1;
            wait_clk(HALF);
         end
         PS2_CLK = 1'b0;
         wait_clk(HALF);
         PS2_CLK = 1'b1;
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                                input int glitch_bit);
      send_frame(b, bad_par, bad_stop, glitch_bit, 11);
      PS2_DATA = 1'b1;
      wait_clk(GAP);
      model_byte(b, bad_par, bad_stop);
   endtask

   task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      applyStimulus(b0, 0, 0, -1);
      applyStimulus(b1, 0, 0, -1);
      applyStimulus(b2, 0, 0, -1);
   endtask

   task automatic check_state(input string tag);
      checkOutput({tag, ".mouse"},   {7'b0, MOUSE}, {7'b0, exp_mouse});
      checkOutput({tag, ".errcyc"},  32'(err_cycles), 32'(exp_errs));
      checkOutput({tag, ".errpls"},  32'(err_pulses), 32'(exp_errs));
      checkOutput({tag, ".toggles"}, 32'(toggles), 32'(exp_toggles));
      checkOutput({tag, ".stable"},  32'(stab_viol), 32'd0);
   endtask

   initial begin
      logic [7:0] rb [3];
      bit         rp [3];
      checks = 0; errors = 0;
      exp_mouse = '0; exp_errs = 0; exp_toggles = 0; exp_idx = 0;
      err_cycles = 0; err_pulses = 0; toggles = 0; stab_viol = 0;
      RESET = 1'b1; PS2_CLK = 1'b1; PS2_DATA = 1'b1;
      wait_clk(5);
      checkOutput("reset.mouse", {7'b0, MOUSE}, 32'd0);
      checkOutput("reset.err", {31'b0, ERR}, 32'd0);
      RESET = 1'b0;
      wait_clk(10);

      send_packet(8'h08, 8'h05, 8'hFB);
      check_state("basic");
      checkOutput("basic.lit", {7'b0, MOUSE}, 32'h1FB0508);

      applyStimulus(8'h08, 1, 0, -1);
      send_packet(8'h08, 8'h01, 8'h02);
      check_state("badpar");
      checkOutput("badpar.lit", {8'b0, MOUSE[23:0]}, 32'h020108);

      applyStimulus(8'h00, 0, 0, -1);
      send_packet(8'h09, 8'h10, 8'h20);
      check_state("sync");
      checkOutput("sync.lit", {8'b0, MOUSE[23:0]}, 32'h201009);

      applyStimulus(8'h08, 0, 1, -1);
      applyStimulus(8'hC8, 0, 0, 4);
      applyStimulus(8'h7F, 0, 0, 9);
      applyStimulus(8'h80, 0, 0, 2);
      check_state("glitch");
      checkOutput("glitch.lit", {8'b0, MOUSE[23:0]}, 32'h807FC8);

      for (int k = 0; k < 8; k++) begin
         for (int j = 0; j < 3; j++) begin
            rb[j] = 8'($urandom);
            rp[j] = ($urandom_range(0, 7) == 0);
         end
         if ($urandom_range(0, 4) != 0) rb[0][3] = 1'b1;
         for (int j = 0; j < 3; j++) applyStimulus(rb[j], rp[j], 0, -1);
         check_state($sformatf("rand%0d", k));
      end

`ifdef PS2_MOUSE_TIMEOUT_EN
      while (exp_idx != 0) applyStimulus(8'h08, 0, 1, -1);
      applyStimulus(8'h08, 0, 0, -1);
      wait_clk(150);
      exp_errs++;
      exp_idx = 0;
      send_packet(8'h0A, 8'h03, 8'h04);
      check_state("timeout");
      checkOutput("timeout.lit", {8'b0, MOUSE[23:0]}, 32'h04030A);
`endif

      send_packet(8'h2C, 8'h11, 8'h22);
      applyStimulus(8'h08, 0, 0, -1);
      send_frame(8'h5A, 0, 0, -1, 5);
      #1 RESET = 1'b1;
      #1 checkOutput("midrst.mouse", {7'b0, MOUSE}, 32'd0);
      PS2_CLK = 1'b1; PS2_DATA = 1'b1;
      exp_mouse = '0; exp_idx = 0;
      wait_clk(5);
      RESET = 1'b0;
      wait_clk(20);
      applyStimulus(8'h01, 0, 0, -1);
      applyStimulus(8'h02, 0, 0, -1);
      checkOutput("midrst.hold", {7'b0, MOUSE}, 32'd0);
      send_packet(8'h18, 8'hFF, 8'h01);
      check_state("postrst");
      checkOutput("postrst.lit", {7'b0, MOUSE}, 32'h101FF18);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
